// File: rtl/lfsr_rand_arbiter_if.sv
// Request/grant and control bundle for lfsr_rand_arbiter; the DUT side uses the slave modport.
interface lfsr_rand_arbiter_if #(
  parameter int unsigned NUM_BITS = 16,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = $clog2(NUM_REQ)
);
  logic                i_Start;
  logic                i_Stop;
  logic                i_Stop_On_Wrap;
  logic [NUM_BITS-1:0] i_Seed_Data;
  logic                i_Reseed;
  logic [NUM_REQ-1:0]  i_Req;
  logic [NUM_REQ-1:0]  o_Gnt;
  logic                o_Rand_DV;
  logic [NUM_BITS-1:0] o_Rand_Data;
  logic [ID_W-1:0]     o_Rand_Id;
  logic                o_Running;
  logic                o_Wrap_Pulse;
  logic [7:0]          o_Wrap_Count;
  logic [NUM_BITS-1:0] o_Step_Count;

  modport master (
    output i_Start, i_Stop, i_Stop_On_Wrap, i_Seed_Data, i_Reseed, i_Req,
    input  o_Gnt, o_Rand_DV, o_Rand_Data, o_Rand_Id, o_Running,
           o_Wrap_Pulse, o_Wrap_Count, o_Step_Count
  );

  modport slave (
    input  i_Start, i_Stop, i_Stop_On_Wrap, i_Seed_Data, i_Reseed, i_Req,
    output o_Gnt, o_Rand_DV, o_Rand_Data, o_Rand_Id, o_Running,
           o_Wrap_Pulse, o_Wrap_Count, o_Step_Count
  );
endinterface

// File: rtl/lfsr_rand_arbiter.sv
// XNOR Fibonacci LFSR with IDLE/RUN sequencing, reseed and wrap tracking, handing
// out one pseudo-random word per cycle to NUM_REQ requesters in round-robin order.
module lfsr_rand_arbiter #(
  parameter int unsigned NUM_BITS = 16,
  parameter int unsigned NUM_REQ  = 4
) (
  input logic                i_Clk,
  input logic                i_Rst_L,
  lfsr_rand_arbiter_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Maximal-length tap sets, bit k-1 set for tap k.
  function automatic logic [15:0] tap_mask(input int unsigned w);
    case (w)
      2:       tap_mask = 16'h0003;
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = '0;
    endcase
  endfunction

  localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(tap_mask(NUM_BITS));

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] seed_reg_q, seed_reg_d;
  logic [NUM_BITS-1:0] lfsr_q, lfsr_d;
  logic [NUM_BITS-1:0] step_q, step_d;
  logic [NUM_BITS-1:0] data_q, data_d;
  logic                reseed_cyc_q, reseed_cyc_d;
  logic                dv_q, dv_d;
  logic                wrap_pulse_q, wrap_pulse_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [7:0]          wrap_cnt_q, wrap_cnt_d;

  logic                run, seed_dv, lfsr_done, wrap_evt, stop_wrap, grant, found;
  logic [ID_W-1:0]     winner, idx;

  // LFSR: an even number of taps chained through XNOR equals inverted parity.
  always_comb begin
    seed_dv   = (state_q == ST_IDLE) || reseed_cyc_q;
    lfsr_done = (lfsr_q == seed_reg_q);
    if (seed_dv) begin
      lfsr_d = seed_reg_q;
    end else begin
      lfsr_d = {lfsr_q[NUM_BITS-2:0], ~(^(lfsr_q & TAPS))};
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && bus.i_Req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    run       = (state_q == ST_RUN);
    wrap_evt  = run && lfsr_done && (step_q != '0) && !reseed_cyc_q;
    // Stopping on a wrap withholds the repeat of the seed word.
    stop_wrap = wrap_evt && bus.i_Stop_On_Wrap && !bus.i_Stop;

    state_d      = state_q;
    seed_reg_d   = seed_reg_q;
    reseed_cyc_d = 1'b0;
    step_d       = '0;
    grant        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        seed_reg_d = bus.i_Seed_Data;
        if (bus.i_Start) state_d = ST_RUN;
      end
      ST_RUN: begin
        grant = found && !reseed_cyc_q && !stop_wrap;
        if (bus.i_Stop || stop_wrap) begin
          state_d = ST_IDLE;
        end else begin
          step_d = (wrap_evt || reseed_cyc_q) ? '0 : step_q + NUM_BITS'(1);
          if (bus.i_Reseed) begin
            seed_reg_d   = bus.i_Seed_Data;
            reseed_cyc_d = 1'b1;
          end
        end
      end
    endcase

    wrap_pulse_d = wrap_evt;
    wrap_cnt_d   = (wrap_evt && wrap_cnt_q != 8'hFF) ? wrap_cnt_q + 8'd1 : wrap_cnt_q;

    gnt_d    = grant ? (NUM_REQ'(1) << winner) : '0;
    dv_d     = grant;
    data_d   = grant ? lfsr_q : '0;
    id_d     = grant ? winner : '0;
    rr_ptr_d = grant ? ID_W'((32'(winner) + 32'd1) % NUM_REQ) : rr_ptr_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= ST_IDLE;
      seed_reg_q   <= '0;
      lfsr_q       <= '0;
      step_q       <= '0;
      data_q       <= '0;
      reseed_cyc_q <= 1'b0;
      dv_q         <= 1'b0;
      wrap_pulse_q <= 1'b0;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      gnt_q        <= '0;
      wrap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      seed_reg_q   <= seed_reg_d;
      lfsr_q       <= lfsr_d;
      step_q       <= step_d;
      data_q       <= data_d;
      reseed_cyc_q <= reseed_cyc_d;
      dv_q         <= dv_d;
      wrap_pulse_q <= wrap_pulse_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      gnt_q        <= gnt_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  assign bus.o_Gnt        = gnt_q;
  assign bus.o_Rand_DV    = dv_q;
  assign bus.o_Rand_Data  = data_q;
  assign bus.o_Rand_Id    = id_q;
  assign bus.o_Running    = (state_q == ST_RUN);
  assign bus.o_Wrap_Pulse = wrap_pulse_q;
  assign bus.o_Wrap_Count = wrap_cnt_q;
  assign bus.o_Step_Count = step_q;
endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Scoreboard bench for lfsr_rand_arbiter (NUM_BITS=4, NUM_REQ=4): a table-driven
// reference pushes expected words/status; a monitor pops and compares.
module tb_lfsr_rand_arbiter;
  localparam int NB     = 4;
  localparam int NR     = 4;
  localparam int PERIOD = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_rand_arbiter_if #(.NUM_BITS(NB), .NUM_REQ(NR)) bus ();
  lfsr_rand_arbiter #(.NUM_BITS(NB), .NUM_REQ(NR)) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (bus)
  );

  // Reference sequence from seed 0; all-ones is the lock-up state.
  logic [NB-1:0] ref_seq [PERIOD] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                                      4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

  typedef struct {
    logic [NR-1:0] gnt;
    logic          dv;
    logic          run;
    logic          pulse;
    logic [7:0]    wcnt;
    logic [NB-1:0] step;
  } stat_t;

  typedef struct {
    logic [NB-1:0] data;
    logic [1:0]    id;
  } word_t;

  stat_t sq[$];
  word_t gq[$];

  int checks = 0, failures = 0;
  int dv_seen = 0, pulse_seen = 0;

  // Stimulus values for the next cycle
  logic          t_start, t_stop, t_sow, t_reseed;
  logic [NB-1:0] t_seed;
  logic [NR-1:0] t_req;

  // Reference state for the cycle about to be sampled
  bit            m_run, m_rcyc;
  logic [NB-1:0] m_seed, m_lfsr;
  int            m_step, m_rr, m_wcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] succ(input logic [NB-1:0] v);
    succ = v;
    for (int i = 0; i < PERIOD; i++)
      if (ref_seq[i] == v) succ = ref_seq[(i + 1) % PERIOD];
  endfunction

  task automatic model_reset();
    m_run = 0; m_rcyc = 0; m_seed = '0; m_lfsr = '0;
    m_step = 0; m_rr = 0; m_wcnt = 0;
  endtask

  task automatic apply_inputs();
    bus.i_Start        = t_start;
    bus.i_Stop         = t_stop;
    bus.i_Stop_On_Wrap = t_sow;
    bus.i_Seed_Data    = t_seed;
    bus.i_Reseed       = t_reseed;
    bus.i_Req          = t_req;
  endtask

  task automatic tick();
    bit    wrap, sow_hit;
    int    win, cand;
    stat_t s;
    word_t w;
    @(negedge clk);
    apply_inputs();
    wrap    = m_run && (m_lfsr == m_seed) && (m_step != 0) && !m_rcyc;
    sow_hit = wrap && t_sow && !t_stop;
    win = -1;
    if (m_run && !m_rcyc && !sow_hit)
      for (int k = 0; k < NR; k++) begin
        cand = (m_rr + k) % NR;
        if (win < 0 && ((t_req >> cand) & 4'd1) != 4'd0) win = cand;
      end
    s.dv  = (win >= 0);
    s.gnt = s.dv ? (NR'(1) << win) : '0;
    if (s.dv) begin
      w.data = m_lfsr;
      w.id   = 2'(win);
      gq.push_back(w);
      m_rr = (win + 1) % NR;
    end
    s.pulse = wrap;
    if (wrap && m_wcnt < 255) m_wcnt++;
    if (!m_run) begin
      m_lfsr = m_seed;
      m_seed = t_seed;
      m_step = 0;
      m_run  = t_start;
      m_rcyc = 0;
    end else begin
      m_lfsr = m_rcyc ? m_seed : succ(m_lfsr);
      if (t_stop || sow_hit) begin
        m_run = 0; m_step = 0; m_rcyc = 0;
      end else begin
        m_step = (wrap || m_rcyc) ? 0 : m_step + 1;
        m_rcyc = t_reseed;
        if (t_reseed) m_seed = t_seed;
      end
    end
    s.run  = m_run;
    s.wcnt = 8'(m_wcnt);
    s.step = NB'(m_step);
    sq.push_back(s);
  endtask

  task automatic pulse_clear();
    t_start = 0; t_stop = 0; t_reseed = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      pulse_clear();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    pulse_clear(); t_sow = 0; t_seed = '0; t_req = '0;
    apply_inputs();
    #1;
    chk("rst_gnt",   bus.o_Gnt,        0);
    chk("rst_dv",    bus.o_Rand_DV,    0);
    chk("rst_data",  bus.o_Rand_Data,  0);
    chk("rst_id",    bus.o_Rand_Id,    0);
    chk("rst_run",   bus.o_Running,    0);
    chk("rst_pulse", bus.o_Wrap_Pulse, 0);
    chk("rst_wcnt",  bus.o_Wrap_Count, 0);
    chk("rst_step",  bus.o_Step_Count, 0);
    sq.delete(); gq.delete();
    model_reset();
    dv_seen = 0; pulse_seen = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor
  initial begin
    stat_t s;
    word_t w;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (bus.o_Rand_DV) begin
          dv_seen++;
          chk("word_expected", gq.size() != 0, 1);
          if (gq.size() != 0) begin
            w = gq.pop_front();
            chk("rand_data", bus.o_Rand_Data, w.data);
            chk("rand_id",   bus.o_Rand_Id,   w.id);
          end
        end
        if (bus.o_Wrap_Pulse) pulse_seen++;
        if (sq.size() != 0) begin
          s = sq.pop_front();
          chk("gnt",        bus.o_Gnt,          s.gnt);
          chk("gnt_onehot", $onehot0(bus.o_Gnt), 1);
          chk("dv",         bus.o_Rand_DV,      s.dv);
          chk("running",    bus.o_Running,      s.run);
          chk("wrap_pulse", bus.o_Wrap_Pulse,   s.pulse);
          chk("wrap_count", bus.o_Wrap_Count,   s.wcnt);
          chk("step_count", bus.o_Step_Count,   s.step);
        end
      end
    end
  end

  initial begin
    pulse_clear(); t_sow = 0; t_seed = '0; t_req = '0;
    apply_inputs();
    model_reset();

    // Seed 0, single requester: the reference stream wrapping past one period
    do_reset();
    ticks(2);
    t_start = 1; t_req = 4'b0001;
    ticks(1);
    ticks(20);

    // Stop on wrap: one period of words, then back to IDLE
    do_reset();
    t_sow = 1;
    ticks(2);
    t_start = 1; t_req = 4'b0001;
    ticks(1);
    ticks(24);
    settle();
    chk("sow_words",  dv_seen,          15);
    chk("sow_pulses", pulse_seen,       1);
    chk("sow_wcnt",   bus.o_Wrap_Count, 1);
    chk("sow_idle",   bus.o_Running,    0);

    // Round-robin with all requesters, then requester 1 dropped
    do_reset();
    ticks(2);
    t_start = 1; t_req = 4'b1111;
    ticks(1);
    ticks(12);
    t_req = 4'b1101;
    ticks(12);

    // Mid-run reseed to 5 at RUN cycle 3
    do_reset();
    ticks(2);
    t_start = 1; t_req = 4'b0001;
    ticks(1);
    ticks(3);
    t_reseed = 1; t_seed = 4'h5;
    ticks(1);
    ticks(10);

    // Randomized traffic with an asynchronous reset in the middle of a run
    do_reset();
    t_seed = ref_seq[$urandom_range(0, PERIOD - 1)];
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
        t_req = 4'b1111;
        ticks(5);
      end
      t_req    = 4'($urandom_range(0, 15));
      t_start  = ($urandom_range(0, 9) == 0);
      t_stop   = ($urandom_range(0, 39) == 0);
      t_reseed = ($urandom_range(0, 14) == 0);
      t_sow    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) t_seed = ref_seq[$urandom_range(0, PERIOD - 1)];
      tick();
      pulse_clear();
    end

    // Stop and reseed together, then run long enough to saturate the wrap count
    do_reset();
    ticks(2);
    t_start = 1; t_req = 4'b0011;
    ticks(1);
    ticks(5);
    t_stop = 1; t_reseed = 1; t_seed = 4'h9;
    ticks(1);
    ticks(3);
    t_start = 1;
    ticks(1);
    for (int i = 0; i < 300 * PERIOD + 20; i++) begin
      t_req = 4'($urandom_range(0, 15));
      tick();
    end
    t_req = '0;
    ticks(2);
    settle();
    chk("wcnt_saturated", bus.o_Wrap_Count, 255);
    chk("words_drained",  gq.size(), 0);
    chk("status_drained", sq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
